// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS execution core: accepts one instruction at a time and steps it
// through DECODE/EXECUTE/MEM/WRITEBACK, owning the register file and data memory.
module mips_multicycle_core #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DMEM_AW = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instrword,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic               branch_taken,
  output logic [DATA_W-1:0]  branch_offset,
  input  logic [4:0]         dbg_reg_addr,
  output logic [DATA_W-1:0]  dbg_reg_data,
  input  logic [DMEM_AW-1:0] dbg_mem_addr,
  output logic [DATA_W-1:0]  dbg_mem_data
);

  localparam int unsigned DMEM_D = 2 ** DMEM_AW;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t             state_q;
  logic [31:0]        ir_q;
  logic [DATA_W-1:0]  a_q, b_q, alu_q, mdr_q;
  logic               done_q, illegal_q, branch_taken_q;
  logic [DATA_W-1:0]  branch_offset_q;
  logic [DATA_W-1:0]  regs_q [32];
  logic [DATA_W-1:0]  mem_q  [DMEM_D];

  // Instruction field decode, always from the latched IR
  logic [5:0]         opcode, funct;
  logic [4:0]         rs, rt, rd, wb_dst;
  logic signed [15:0] imm_s;
  logic [DATA_W-1:0]  imm_sext, alu_res, wb_val;
  logic               op_r, op_lw, op_sw, op_addi, op_beq, funct_ok, legal, slt_res;
  logic [DMEM_AW-1:0] mem_idx;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_s    = ir_q[15:0];
  assign imm_sext = DATA_W'(imm_s);

  assign op_r    = (opcode == OP_RTYPE);
  assign op_lw   = (opcode == OP_LW);
  assign op_sw   = (opcode == OP_SW);
  assign op_addi = (opcode == OP_ADDI);
  assign op_beq  = (opcode == OP_BEQ);
  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_NOR) || (funct == FN_SLT);
  assign legal   = (op_r && funct_ok) || op_lw || op_sw || op_addi || op_beq;

  assign slt_res = ($signed(a_q) < $signed(b_q));
  assign mem_idx = alu_q[DMEM_AW+1:2];
  assign wb_dst  = op_r ? rd : rt;
  assign wb_val  = op_lw ? mdr_q : alu_q;

  always_comb begin
    alu_res = a_q + imm_sext;
    if (op_r) begin
      unique case (funct)
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_NOR:  alu_res = ~(a_q | b_q);
        FN_SLT:  alu_res = DATA_W'(slt_res);
        default: alu_res = a_q + b_q;
      endcase
    end else if (op_beq) begin
      alu_res = a_q - b_q;
    end
  end

  // Control FSM together with datapath, register file and memory updates
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      ir_q            <= '0;
      a_q             <= '0;
      b_q             <= '0;
      alu_q           <= '0;
      mdr_q           <= '0;
      done_q          <= 1'b0;
      illegal_q       <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_offset_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      for (int unsigned j = 0; j < DMEM_D; j++) mem_q[j] <= '0;
    end else begin
      done_q         <= 1'b0;
      illegal_q      <= 1'b0;
      branch_taken_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (instr_valid) begin
            ir_q    <= instrword;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q <= regs_q[rs];
          b_q <= regs_q[rt];
          if (legal) begin
            state_q <= S_EXEC;
          end else begin
            state_q   <= S_IDLE;
            done_q    <= 1'b1;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          alu_q <= alu_res;
          if (op_lw || op_sw) begin
            state_q <= S_MEM;
          end else if (op_beq) begin
            state_q         <= S_IDLE;
            done_q          <= 1'b1;
            branch_taken_q  <= (a_q == b_q);
            branch_offset_q <= imm_sext;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (op_lw) begin
            mdr_q   <= mem_q[mem_idx];
            state_q <= S_WB;
          end else begin
            mem_q[mem_idx] <= b_q;
            state_q        <= S_IDLE;
            done_q         <= 1'b1;
          end
        end
        S_WB: begin
          if (wb_dst != 5'd0) regs_q[wb_dst] <= wb_val;
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready   = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign illegal       = illegal_q;
  assign branch_taken  = branch_taken_q;
  assign branch_offset = branch_offset_q;
  assign dbg_reg_data  = regs_q[dbg_reg_addr];
  assign dbg_mem_data  = mem_q[dbg_mem_addr];

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: hand-computed register, memory,
// latency and pulse expectations checked with immediate assertions.
module tb_mips_multicycle_core;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DMEM_AW = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               instr_valid = 1'b0;
  logic               instr_ready;
  logic [31:0]        instrword = '0;
  logic               busy, done, illegal, branch_taken;
  logic [DATA_W-1:0]  branch_offset;
  logic [4:0]         dbg_reg_addr = '0;
  logic [DATA_W-1:0]  dbg_reg_data;
  logic [DMEM_AW-1:0] dbg_mem_addr = '0;
  logic [DATA_W-1:0]  dbg_mem_data;

  int errors = 0;
  int checks = 0;

  mips_multicycle_core #(.DATA_W(DATA_W), .DMEM_AW(DMEM_AW)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instrword(instrword),
    .busy(busy), .done(done), .illegal(illegal),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .dbg_reg_addr(dbg_reg_addr), .dbg_reg_data(dbg_reg_data),
    .dbg_mem_addr(dbg_mem_addr), .dbg_mem_data(dbg_mem_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_reg_addr = idx;
    #1;
    check(tag, dbg_reg_data, exp);
  endtask

  task automatic chk_mem(input string tag, input logic [DMEM_AW-1:0] idx, input logic [31:0] exp);
    dbg_mem_addr = idx;
    #1;
    check(tag, dbg_mem_data, exp);
  endtask

  // Issue one instruction from IDLE and check latency plus the retire pulses
  task automatic issue(input string tag, input logic [31:0] word, input int exp_lat,
                       input logic exp_ill, input logic exp_br);
    int n;
    check({tag, "_ready"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instrword   = word;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instrword   = 32'hFFFF_FFFF;
    n = 1;
    while (!done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    check({tag, "_branch"}, 32'(branch_taken), 32'(exp_br));
  endtask

  initial begin
    int dones;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_branch", 32'(branch_taken), 32'd0);
    check("rst_offset", branch_offset, 32'd0);
    chk_reg("rst_r5", 5'd5, 32'd0);
    chk_mem("rst_m0", 7'd0, 32'd0);

    issue("addi_r1", enc_i(6'd8, 5'd0, 5'd1, 16'd5), 4, 1'b0, 1'b0);
    issue("addi_r2", enc_i(6'd8, 5'd0, 5'd2, 16'hFFFD), 4, 1'b0, 1'b0);
    chk_reg("r1", 5'd1, 32'd5);
    chk_reg("r2", 5'd2, 32'hFFFF_FFFD);

    issue("add", enc_r(5'd1, 5'd2, 5'd3, 6'd32), 4, 1'b0, 1'b0);
    issue("sub", enc_r(5'd1, 5'd2, 5'd4, 6'd34), 4, 1'b0, 1'b0);
    issue("slt", enc_r(5'd2, 5'd1, 5'd5, 6'd42), 4, 1'b0, 1'b0);
    issue("nor", enc_r(5'd0, 5'd0, 5'd6, 6'd39), 4, 1'b0, 1'b0);
    issue("and", enc_r(5'd1, 5'd2, 5'd8, 6'd36), 4, 1'b0, 1'b0);
    issue("or",  enc_r(5'd1, 5'd2, 5'd9, 6'd37), 4, 1'b0, 1'b0);
    issue("slt0", enc_r(5'd1, 5'd2, 5'd10, 6'd42), 4, 1'b0, 1'b0);
    chk_reg("r3_add", 5'd3, 32'd2);
    chk_reg("r4_sub", 5'd4, 32'd8);
    chk_reg("r5_slt", 5'd5, 32'd1);
    chk_reg("r6_nor", 5'd6, 32'hFFFF_FFFF);
    chk_reg("r8_and", 5'd8, 32'd5);
    chk_reg("r9_or", 5'd9, 32'hFFFF_FFFD);
    chk_reg("r10_slt_signed", 5'd10, 32'd0);

    issue("sw8", enc_i(6'd43, 5'd0, 5'd1, 16'd8), 4, 1'b0, 1'b0);
    chk_mem("m2", 7'd2, 32'd5);
    issue("lw8", enc_i(6'd35, 5'd0, 5'd7, 16'd8), 5, 1'b0, 1'b0);
    chk_reg("r7_lw", 5'd7, 32'd5);
    issue("sw512", enc_i(6'd43, 5'd0, 5'd1, 16'd512), 4, 1'b0, 1'b0);
    chk_mem("m0_wrap", 7'd0, 32'd5);

    issue("beq_t", enc_i(6'd4, 5'd1, 5'd1, 16'hFFFC), 3, 1'b0, 1'b1);
    check("beq_offset", branch_offset, 32'hFFFF_FFFC);
    issue("beq_nt", enc_i(6'd4, 5'd1, 5'd2, 16'd4), 3, 1'b0, 1'b0);

    issue("ill_j", {6'd2, 26'h000_0010}, 2, 1'b1, 1'b0);
    issue("ill_fn0", enc_r(5'd1, 5'd2, 5'd11, 6'd0), 2, 1'b1, 1'b0);
    chk_reg("r11_untouched", 5'd11, 32'd0);
    chk_reg("r1_untouched", 5'd1, 32'd5);
    chk_mem("m1_untouched", 7'd1, 32'd0);
    issue("addi_r0", enc_i(6'd8, 5'd0, 5'd0, 16'd7), 4, 1'b0, 1'b0);
    chk_reg("r0_zero", 5'd0, 32'd0);

    // Valid held high: one accept every 4 edges, ready only while idle
    instr_valid = 1'b1;
    instrword   = enc_i(6'd8, 5'd12, 5'd12, 16'd1);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      if (i == 0) check("b2b_busy", 32'(busy), 32'd1);
    end
    instr_valid = 1'b0;
    check("b2b_dones", 32'(dones), 32'd3);
    chk_reg("r12_b2b", 5'd12, 32'd3);

    // Reset while a store to mem[3] sits in MEM
    instr_valid = 1'b1;
    instrword   = enc_i(6'd43, 5'd0, 5'd1, 16'd12);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(instr_ready), 32'd1);
    chk_mem("abort_m3", 7'd3, 32'd0);
    chk_mem("abort_m2", 7'd2, 32'd0);
    chk_reg("abort_r1", 5'd1, 32'd0);
    chk_reg("abort_r12", 5'd12, 32'd0);
    @(posedge clk);
    #1;
    check("abort_done2", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Parametrised multicycle MIPS execution core; successor to the single-instruction datapath with FSM control.
- Accepts one instruction word at a time over a valid/ready handshake.
- Runs it through a registered DECODE/EXECUTE/MEM/WRITEBACK state machine, then reports completion and branch outcome.
- Owns the register file and data memory.
- PC and instruction fetch stay outside, in the fetch unit, which consumes branch_taken/branch_offset.

Parameters:
DATA_W, 32, datapath/register/memory word width (>=16).
DMEM_AW, 7, data memory word-address width; depth = 2**DMEM_AW words.

Ports:
clk  in  1  clock; all state changes on rising edge.
rst  in  1  reset, synchronous, active-high.
instr_valid  in  1  instrword is presented.
instr_ready  out  1  core is in IDLE and can accept an instruction.
instrword  in  32  MIPS instruction; sampled only on accept (instr_valid & instr_ready).
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse: instruction retired.
illegal  out  1  one-cycle pulse with done: unsupported opcode/funct.
branch_taken  out  1  one-cycle pulse with done: beq condition true.
branch_offset  out  DATA_W  sign-extended imm16, valid while branch_taken is high.
dbg_reg_addr  in  5  debug register read index.
dbg_reg_data  out  DATA_W  combinational read of register[dbg_reg_addr].
dbg_mem_addr  in  DMEM_AW  debug memory read index.
dbg_mem_data  out  DATA_W  combinational read of memory[dbg_mem_addr].

Behaviour:
- Reset (rst high at an edge), priority over everything:
  - state = IDLE.
  - All 32 registers and all memory words = 0.
  - instr_ready = 1; busy, done, illegal, branch_taken = 0; branch_offset = 0.
  - Reset during any state aborts the instruction: nothing written that edge, no done pulse.
- Internal registers: IR, A, B, ALUOut, MDR; all loaded only in the states listed below.
- States and transitions:
  - IDLE: instr_ready = 1. On accept, IR <= instrword, go to DECODE.
  - DECODE: A <= reg[rs], B <= reg[rt]. Decode opcode:
    - 0 (R-type, funct add 32 / sub 34 / and 36 / or 37 / nor 39 / slt 42) -> EXECUTE.
    - lw 35, sw 43, addi 8, beq 4 -> EXECUTE.
    - Anything else, including an R-type with unlisted funct -> IDLE with done = illegal = 1.
  - EXECUTE, ALUOut <= :
    - R-type: A op B. slt compares signed and yields 1/0.
    - lw/sw/addi: A + sext(imm16).
    - beq: ALUOut = A - B.
    - Next state: R-type/addi -> WRITEBACK. lw/sw -> MEM. beq -> IDLE with done = 1, branch_taken = (A == B), branch_offset = sext(imm16).
  - MEM: word index = ALUOut[DMEM_AW+1:2]; higher bits are ignored (wrap); bits [1:0] are ignored.
    - lw: MDR <= mem[index] -> WRITEBACK.
    - sw: mem[index] <= B -> IDLE with done = 1.
  - WRITEBACK: the write is suppressed when the destination is 0; register 0 always reads 0. Then -> IDLE with done = 1.
    - R-type: reg[rd] <= ALUOut.
    - addi: reg[rt] <= ALUOut.
    - lw: reg[rt] <= MDR.
- Arithmetic: all results are truncated to DATA_W (overflow wraps, no trap). sext extends bit 15 to DATA_W.
- done, illegal, branch_taken are registered. They assert on the edge the FSM re-enters IDLE and stay high exactly one cycle.
- Latency, in edges from the accept edge to the done-high cycle:
  - R-type, addi, sw: 4.
  - lw: 5.
  - beq: 3.
  - illegal: 2.
- Back-to-back: instr_ready is high in the done cycle, so the next accept can occur there. instr_valid outside IDLE is ignored, and instrword may change freely.
- Read-after-write: an instruction accepted after a retired write sees the new value; no forwarding is needed because there is no overlap.
- Debug reads are pure combinational views and never affect state.

Test Plan:
- Reset, then addi r1,r0,5 then addi r2,r0,-3 -> done 4 edges after each accept; dbg reg1 = 5, reg2 = 0xFFFFFFFD.
- With r1 = 5, r2 = -3, issue add r3,r1,r2; sub r4,r1,r2; slt r5,r2,r1; nor r6,r0,r0 -> r3 = 2, r4 = 8, r5 = 1 (signed), r6 = 0xFFFFFFFF.
- sw r1,8(r0), then lw r7,8(r0) -> dbg mem[2] = 5, r7 = 5; lw done at 5 edges. sw r1,512(r0) with DMEM_AW = 7 wraps -> mem[0] = 5.
- beq r1,r1,-4 -> branch_taken pulse with done 3 edges after accept, branch_offset = 0xFFFFFFFC. beq r1,r2,4 -> done with branch_taken = 0.
- Opcode 2 (j) or R-type funct 0 -> done + illegal at 2 edges, no register/memory change. addi r0,r0,7 -> r0 stays 0.
- Assert rst in MEM of a sw to mem[3] -> no done pulse, mem[3] = 0, all registers 0, instr_ready = 1 next cycle. Hold instr_valid high continuously -> accepts occur only in done/IDLE cycles.
